// File: rtl/vga_trace_sweep.sv
// Column/channel sweep generator: walks NCH trace points per column and produces
// sample-buffer read addresses. VGA_SWEEP_TRIG_OFFSET_EN makes trig_addr the sweep base.
module vga_trace_sweep #(
    parameter int unsigned       X_W         = 8,
    parameter int unsigned       X_LAST      = 159,
    parameter int unsigned       NCH         = 2,
    parameter int unsigned       ADDR_W      = 11,
    parameter int unsigned       DIV_W       = 2,
    parameter logic [12*NCH-1:0] COLOR_TABLE = {12'h0F0, 12'hF00},
    localparam int unsigned      CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    input  logic [DIV_W-1:0]  time_division,
    input  logic [ADDR_W-1:0] trig_addr,
    output logic [X_W-1:0]    CounterX,
    output logic [CH_W-1:0]   channel,
    output logic [ADDR_W-1:0] read_CounterX,
    output logic [11:0]       color,
    output logic              valid,
    output logic              busy,
    output logic              finished
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] step;
    logic              last_ch;
    logic              last_col;

`ifdef VGA_SWEEP_TRIG_OFFSET_EN
    assign base = trig_addr;
`else
    logic unused_trig_addr;
    assign unused_trig_addr = ^trig_addr;
    assign base = '0;
`endif

    // Step is re-evaluated at every column advance, so a new division applies next column.
    assign step     = ADDR_W'(time_division) + ADDR_W'(1);
    assign last_ch  = (ch_q == CH_W'(NCH - 1));
    assign last_col = (x_q == X_W'(X_LAST));

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        ch_d     = ch_q;
        addr_d   = addr_q;
        valid    = 1'b0;
        busy     = 1'b0;
        finished = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSweep;
                    x_d     = '0;
                    ch_d    = '0;
                    addr_d  = base;
                end
            end
            StSweep: begin
                busy  = 1'b1;
                valid = enable;
                if (enable) begin
                    if (!last_ch) begin
                        ch_d = ch_q + CH_W'(1);
                    end else if (!last_col) begin
                        ch_d   = '0;
                        x_d    = x_q + X_W'(1);
                        addr_d = addr_q + step;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                finished = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
        end
    end

    assign CounterX      = x_q;
    assign channel       = ch_q;
    assign read_CounterX = addr_q;
    assign color         = COLOR_TABLE[12*ch_q +: 12];

endmodule

// File: tb/tb_vga_trace_sweep.sv
// Randomized scoreboard bench for vga_trace_sweep: stimulus predicts each consumed point,
// a negedge monitor pops and compares whenever valid is seen.
module tb_vga_trace_sweep;

    localparam int X_W    = 8;
    localparam int X_LAST = 159;
    localparam int NCH    = 2;
    localparam int ADDR_W = 11;
    localparam int DIV_W  = 2;
    localparam int CH_W   = 1;

    logic              clk = 1'b0;
    logic              reset, start, enable;
    logic [DIV_W-1:0]  time_division;
    logic [ADDR_W-1:0] trig_addr;
    logic [X_W-1:0]    CounterX;
    logic [CH_W-1:0]   channel;
    logic [ADDR_W-1:0] read_CounterX;
    logic [11:0]       color;
    logic              valid, busy, finished;

    vga_trace_sweep dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enable       (enable),
        .time_division(time_division),
        .trig_addr    (trig_addr),
        .CounterX     (CounterX),
        .channel      (channel),
        .read_CounterX(read_CounterX),
        .color        (color),
        .valid        (valid),
        .busy         (busy),
        .finished     (finished)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int ch;
        int addr;
    } pt_t;

    pt_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_on  = 1'b0;
    bit  exp_busy, exp_fin, exp_valid;
    int  exp_x, exp_ch, exp_addr;

    function automatic int colour_of(input int ch);
        return (ch == 0) ? 'hF00 : 'h0F0;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", int'(busy), int'(exp_busy));
            chk("finished", int'(finished), int'(exp_fin));
            chk("valid", int'(valid), int'(exp_valid));
            if (valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow at %0t: got point x=%0d ch=%0d expected none",
                             $time, CounterX, channel);
                end else begin
                    pt_t p;
                    p = sb.pop_front();
                    chk("pt_x", int'(CounterX), p.x);
                    chk("pt_ch", int'(channel), p.ch);
                    chk("pt_addr", int'(read_CounterX), p.addr);
                    chk("pt_color", int'(color), colour_of(p.ch));
                end
            end else begin
                chk("hold_x", int'(CounterX), exp_x);
                chk("hold_ch", int'(channel), exp_ch);
                chk("hold_addr", int'(read_CounterX), exp_addr);
                chk("hold_color", int'(color), colour_of(exp_ch));
            end
        end
    end

    // One sweep; td_fixed<0 means random division changes, abort_col>=0 resets at that column.
    task automatic do_sweep(input int en_pct, input int td_fixed, input int abort_col);
        int k, addr, td, total;
        bit en;
        total     = NCH * (X_LAST + 1);
        trig_addr = ADDR_W'($urandom_range((1 << ADDR_W) - 1));
`ifdef VGA_SWEEP_TRIG_OFFSET_EN
        addr = int'(trig_addr);
`else
        addr = 0;
`endif
        start     = 1'b1;
        enable    = 1'($urandom_range(1));
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_busy = 1'b1;
        td       = (td_fixed < 0) ? int'($urandom_range(3)) : td_fixed;
        k        = 0;
        while (k < total) begin
            exp_x    = k / NCH;
            exp_ch   = k % NCH;
            exp_addr = addr;
            if (abort_col >= 0 && k == abort_col * NCH) begin
                reset     = 1'b1;
                start     = 1'b1;
                enable    = 1'b0;
                exp_valid = 1'b0;
                @(posedge clk); #1;
                reset    = 1'b0;
                start    = 1'b0;
                exp_busy = 1'b0;
                exp_x    = 0;
                exp_ch   = 0;
                exp_addr = 0;
                @(posedge clk); #1;
                return;
            end
            en = ($urandom_range(99) < en_pct);
            if (td_fixed < 0 && $urandom_range(7) == 0) td = int'($urandom_range(3));
            enable        = en;
            time_division = DIV_W'(td);
            start         = ($urandom_range(15) == 0);
            exp_valid     = en;
            if (en) begin
                sb.push_back('{exp_x, exp_ch, addr});
                if (exp_ch == NCH - 1 && exp_x < X_LAST) addr = (addr + td + 1) % (1 << ADDR_W);
                k++;
            end
            @(posedge clk); #1;
        end
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
        exp_fin   = 1'b1;
        start     = 1'b1;
        enable    = 1'($urandom_range(1));
        @(posedge clk); #1;
        exp_fin = 1'b0;
        start   = 1'b0;
        repeat (3) begin
            enable        = 1'($urandom_range(1));
            time_division = DIV_W'($urandom_range(3));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        enable        = 1'b0;
        time_division = '0;
        trig_addr     = '0;
        exp_busy      = 1'b0;
        exp_fin       = 1'b0;
        exp_valid     = 1'b0;
        exp_x         = 0;
        exp_ch        = 0;
        exp_addr      = 0;
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        start  = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        do_sweep(100, 0, -1);
        do_sweep(100, 3, -1);
        do_sweep(60, -1, -1);
        do_sweep(70, -1, 50);
        do_sweep(80, -1, -1);
        repeat (2) do_sweep(int'($urandom_range(100, 30)), -1, -1);

        @(posedge clk); #1;
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
